// File: rtl/fifo_enq_arbiter_pkg.sv
// Shared definitions for the FIFO enqueue arbiter.
//   arb_state_e : lock FSM states (IDLE, LOCKED)
//   rr_next     : round-robin wrap-around increment (n-1 -> 0)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_enq_arbiter_if.sv
// Handshake bundle between the producers, the arbiter and the FIFO enqueue port.
//   req_data  : packed beats, requester i at [i*data_size +: data_size]
//   req_last  : per-requester end-of-burst flag
//   req_valid : per-requester beat offered
//   req_ready : per-requester beat accepted
//   out_data  : forwarded beat      out_id    : granted requester index
//   out_last  : forwarded last flag out_valid : to FIFO enq_valid
//   out_ready : from FIFO enq_ready
// master = producer/FIFO side (bench), slave = arbiter side.
interface fifo_enq_arbiter_if #(
  parameter int num_req   = 4,
  parameter int data_size = 32
);
  localparam int id_size = $clog2(num_req);

  logic [num_req*data_size-1:0] req_data;
  logic [num_req-1:0]           req_last;
  logic [num_req-1:0]           req_valid;
  logic [num_req-1:0]           req_ready;
  logic [data_size-1:0]         out_data;
  logic [id_size-1:0]           out_id;
  logic                         out_last;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output req_data, req_last, req_valid, out_ready,
    input  req_ready, out_data, out_id, out_last, out_valid
  );

  modport slave (
    input  req_data, req_last, req_valid, out_ready,
    output req_ready, out_data, out_id, out_last, out_valid
  );

endinterface

// File: rtl/fifo_enq_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req        : request vector
//   ptr        : priority start index
//   gnt_onehot : one-hot grant (all zero when no request)
//   gnt_idx    : grant index (0 when no request)
//   any        : at least one request present
// Masked/unmasked double priority encode: the lowest request at or above ptr
// wins; if there is none, the lowest request overall wins (wrap-around).
module rr_picker #(
  parameter int num_req = 4,
  localparam int id_size = $clog2(num_req)
) (
  input  logic [num_req-1:0] req,
  input  logic [id_size-1:0] ptr,
  output logic [num_req-1:0] gnt_onehot,
  output logic [id_size-1:0] gnt_idx,
  output logic               any
);

  logic [num_req-1:0] masked;
  logic [id_size-1:0] idx_m;
  logic [id_size-1:0] idx_u;

  always_comb begin
    masked = '0;
    idx_m  = '0;
    idx_u  = '0;
    // Descending scan so the lowest set bit is the last one assigned.
    for (int i = num_req - 1; i >= 0; i--) begin
      masked[i] = req[i] && (i >= int'(ptr));
      if (req[i])    idx_u = id_size'(i);
      if (masked[i]) idx_m = id_size'(i);
    end
    any        = |req;
    gnt_idx    = (|masked) ? idx_m : idx_u;
    gnt_onehot = any ? (num_req'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing one FIFO enqueue port between num_req producers.
// Multi-beat bursts (terminated by last) stay contiguous; each beat is tagged
// with the granted requester index.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous abort, drops the lock and resets the pointer
//   bus        : handshake bundle (slave modport), see fifo_enq_arbiter_if
//   busy       : high while a burst is locked
module fifo_enq_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int num_req   = 4,
  parameter int data_size = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  fifo_enq_arbiter_if.slave     bus,
  output logic                  busy
);

  localparam int id_size = $clog2(num_req);

  arb_state_e         state_q, state_d;
  logic [id_size-1:0] ptr_q, ptr_d;
  logic [id_size-1:0] owner_q, owner_d;

  logic [num_req-1:0] pick_onehot;
  logic [id_size-1:0] pick_idx;
  logic               pick_any;

  logic [id_size-1:0] gnt;
  logic [num_req-1:0] gnt_onehot;
  logic               offer;
  logic               xfer;
  logic               gnt_last;

  rr_picker #(.num_req(num_req)) u_picker (
    .req        (bus.req_valid),
    .ptr        (ptr_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // While locked only the owner may be forwarded, even if its valid is low.
  always_comb begin
    if (state_q == LOCKED) begin
      gnt        = owner_q;
      gnt_onehot = num_req'(1) << owner_q;
      offer      = bus.req_valid[owner_q];
    end else begin
      gnt        = pick_idx;
      gnt_onehot = pick_onehot;
      offer      = pick_any;
    end
  end

  // Data and last are zeroed when nothing is offered so an idle port is all-zero.
  assign gnt_last      = bus.req_last[gnt];
  assign bus.out_id    = gnt;
  assign bus.out_data  = offer ? bus.req_data[int'(gnt)*data_size +: data_size] : '0;
  assign bus.out_last  = offer & gnt_last;
  assign bus.out_valid = offer & ~flush;
  assign xfer          = bus.out_valid & bus.out_ready;
  assign bus.req_ready = xfer ? gnt_onehot : '0;
  assign busy          = (state_q == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Flush overrides any transfer in the same cycle; without a transfer all state holds.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (flush) begin
      state_d = IDLE;
      ptr_d   = '0;
      owner_d = '0;
    end else if (xfer) begin
      if (gnt_last) begin
        state_d = IDLE;
        ptr_d   = id_size'(rr_next(int'(gnt), num_req));
      end else begin
        state_d = LOCKED;
        owner_d = gnt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
module tb_fifo_enq_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_enq_arbiter_if #(.num_req(4), .data_size(32)) bus ();

  fifo_enq_arbiter #(.num_req(4), .data_size(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dword(input int i, input logic [7:0] beat);
    return {8'hA0 + 8'(i), 16'h0000, beat};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                       input logic [7:0] beat);
    for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = dword(i, beat);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one accepted beat from requester id, then advances one cycle.
  task automatic expect_beat(input string tag, input int id, input logic last,
                             input logic [7:0] beat, input logic bsy);
    logic [3:0] rdy;
    rdy = 4'b0001 << id;
    chk({tag, "_vld"},  bus.out_valid, 1'b1);
    chk({tag, "_id"},   bus.out_id, id);
    chk({tag, "_rdy"},  bus.req_ready, rdy);
    chk({tag, "_data"}, bus.out_data, dword(id, beat));
    chk({tag, "_last"}, bus.out_last, last);
    chk({tag, "_busy"}, busy, bsy);
    tick();
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_vld"},  bus.out_valid, 1'b0);
    chk({tag, "_id"},   bus.out_id, 2'd0);
    chk({tag, "_rdy"},  bus.req_ready, 4'b0000);
    chk({tag, "_data"}, bus.out_data, 32'h0);
    chk({tag, "_last"}, bus.out_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 8'h00);
    #3;
    chk("rst_busy", busy, 1'b0);
    #8;
    rst_n = 1'b1;
    tick();
    expect_idle("reset");

    // Round-robin over single-beat bursts: 0,1,2,3,0,1 (ptr ends at 2).
    drive(4'b1111, 4'b1111, 1'b1, 8'h00);
    for (int k = 0; k < 6; k++) expect_beat("rr", k % 4, 1'b1, 8'h00, 1'b0);

    // Flush with everyone valid: nothing accepted; pointer back to 0.
    flush = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1, 8'h00);
    chk("fl0_vld", bus.out_valid, 1'b0);
    chk("fl0_rdy", bus.req_ready, 4'b0000);
    tick();
    flush = 1'b0;

    // Burst lock on req1 while req0/req2 are also valid.
    drive(4'b0001, 4'b1111, 1'b1, 8'h00);
    expect_beat("b0", 0, 1'b1, 8'h00, 1'b0);
    drive(4'b0111, 4'b1101, 1'b1, 8'h01);
    expect_beat("lk1", 1, 1'b0, 8'h01, 1'b0);
    drive(4'b0111, 4'b1101, 1'b1, 8'h02);
    expect_beat("lk2", 1, 1'b0, 8'h02, 1'b1);
    drive(4'b0111, 4'b1111, 1'b1, 8'h03);
    expect_beat("lk3", 1, 1'b1, 8'h03, 1'b1);
    drive(4'b0101, 4'b1111, 1'b1, 8'h04);
    expect_beat("after", 2, 1'b1, 8'h04, 1'b0);

    // Backpressure mid-burst of req3 (ptr=3 here).
    drive(4'b1111, 4'b0111, 1'b1, 8'h05);
    expect_beat("bp0", 3, 1'b0, 8'h05, 1'b0);
    drive(4'b1111, 4'b0111, 1'b0, 8'h06);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rdy",  bus.req_ready, 4'b0000);
      chk("bp_vld",  bus.out_valid, 1'b1);
      chk("bp_id",   bus.out_id, 2'd3);
      chk("bp_data", bus.out_data, dword(3, 8'h06));
      chk("bp_busy", busy, 1'b1);
      tick();
    end
    drive(4'b1111, 4'b1111, 1'b1, 8'h06);
    expect_beat("bp_rel", 3, 1'b1, 8'h06, 1'b1);

    // Flush mid-burst of req2: ptr restored to 0, so req0 beats req2 afterwards.
    drive(4'b0010, 4'b1111, 1'b1, 8'h07);
    expect_beat("f_pre", 1, 1'b1, 8'h07, 1'b0);
    drive(4'b0100, 4'b0000, 1'b1, 8'h08);
    expect_beat("f_lk", 2, 1'b0, 8'h08, 1'b0);
    flush = 1'b1;
    drive(4'b0101, 4'b1111, 1'b1, 8'h09);
    chk("fl_rdy",  bus.req_ready, 4'b0000);
    chk("fl_vld",  bus.out_valid, 1'b0);
    chk("fl_busy", busy, 1'b1);
    tick();
    flush = 1'b0;
    drive(4'b0101, 4'b1111, 1'b1, 8'h0A);
    expect_beat("f_post", 0, 1'b1, 8'h0A, 1'b0);

    // Wrap: ptr=3 with only req0/req3 valid -> 3,0,3,0.
    drive(4'b0100, 4'b1111, 1'b1, 8'h0B);
    expect_beat("w_pre", 2, 1'b1, 8'h0B, 1'b0);
    drive(4'b1001, 4'b1111, 1'b1, 8'h0C);
    expect_beat("w0", 3, 1'b1, 8'h0C, 1'b0);
    expect_beat("w1", 0, 1'b1, 8'h0C, 1'b0);
    expect_beat("w2", 3, 1'b1, 8'h0C, 1'b0);
    expect_beat("w3", 0, 1'b1, 8'h0C, 1'b0);

    // Asynchronous reset while locked.
    drive(4'b0010, 4'b0000, 1'b1, 8'h0D);
    expect_beat("r_lk", 1, 1'b0, 8'h0D, 1'b0);
    drive(4'b0010, 4'b0000, 1'b0, 8'h0E);
    chk("r_busy_pre", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_busy_async", busy, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0, 8'h00);
    #2;
    rst_n = 1'b1;
    tick();
    expect_idle("r_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_enq_arbiter.md
# fifo_enq_arbiter

Round-robin arbiter that shares the enqueue port of one `fifo` instance between `num_req` independent producers. It forwards one beat per cycle using the valid/ready handshake. It keeps a multi-beat burst (terminated by `last`) contiguous, and tags each beat with the winning requester index. It sits directly in front of the FIFO's `enq_*` port and is flushed together with it.

## Interface
- `num_req`, default 4: number of requesters, ≥2.
- `data_size`, default 32: beat width, equal to the downstream FIFO payload minus the tag and last bits.
- `id_size`, default `$clog2(num_req)`: tag width. Localparam, not overridable.
- `clk` in 1: clock. Reset is `rst_n`, asynchronous, active-low. Clock is `clk`.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous abort. Drops the lock and restores the pointer.
- `req_data` in `num_req*data_size`: packed beats; requester i occupies bits `[i*data_size +: data_size]`.
- `req_last` in `num_req`: final beat of the burst.
- `req_valid` in `num_req`: beat offered.
- `req_ready` out `num_req`: beat accepted this cycle.
- `out_data` out `data_size`: to the FIFO `enq_data` data field.
- `out_id` out `id_size`: index of the granted requester.
- `out_last` out 1: last flag of the forwarded beat.
- `out_valid` out 1: to the FIFO `enq_valid`.
- `out_ready` in 1: from the FIFO `enq_ready`.
- `busy` out 1: registered; high while a burst is locked.

## Operation
- **State machine:**
  - State is IDLE or LOCKED, plus registers `ptr` (priority start, `id_size` bits) and `owner` (`id_size` bits).
  - **IDLE:** grant goes to the first requester with `req_valid` set, searching from `ptr` upward and wrapping from `num_req-1` to 0.
  - **LOCKED:** grant is `owner` only. `out_valid` equals `req_valid[owner]`. Every other `req_ready` is 0, even when the owner's valid is low.
- **Forwarding:**
  - `out_data`, `out_last` and `out_id` are muxed from the granted requester.
  - `req_ready[g] = out_ready & out_valid & !flush`.
  - All other `req_ready` bits are 0.
- **Transfer** means `out_valid & out_ready & !flush`.
- **Transfer with `last`=0:**
  - From IDLE: go to LOCKED and set `owner = g`.
  - From LOCKED: stay in LOCKED.
- **Transfer with `last`=1:**
  - Go to (or stay in) IDLE.
  - Set `ptr = (g == num_req-1) ? 0 : g+1`.
  - A single-beat burst never enters LOCKED.
- **No transfer:** state, `ptr` and `owner` hold. A grant offered while `out_ready`=0 is not committed; the next cycle may re-arbitrate.
- **`flush`:**
  - All `req_ready` and `out_valid` are 0 in the flush cycle.
  - Next state is IDLE, `ptr=0`, `owner=0`.
  - `flush` wins over a simultaneous transfer.
- **Reset:** IDLE, `ptr=0`, `owner=0`, `busy=0`.
  - With all `req_valid` low, every combinational output is 0, including `out_id=0`.
- **Fairness:** an active requester waits at most `num_req-1` bursts.
- **Starvation:** a locked owner that stalls its valid stalls everyone. This is intended behaviour, not an error.

## Timing
- **Latency:** combinational request-to-output, 0 cycles. No register sits between `req_*` and `out_*`.
- **Throughput:** one beat per cycle, including back-to-back bursts from different requesters with no bubble.
- **Registered state:** `busy`, `ptr` and `owner` update on the rising clk edge after the transfer.
- **Combinational paths:** `out_ready` → `req_ready` is a combinational path. The FIFO's `enq_ready` must be registered-derived (the `fifo` full flag is).
- **Reset:** takes effect immediately (asynchronous). A burst cut mid-way by reset or `flush` is not completed. The downstream FIFO must be flushed in the same cycle.

## Structure
- **Shared package `fifo_arb_pkg`:**
  - `arb_state_e` enum {IDLE, LOCKED}.
  - Function `rr_next(idx, n)` implementing the wrap-around increment.
- **Sub-module `rr_picker`:**
  - Combinational; inputs `req[num_req]` and `ptr`.
  - Outputs `gnt_onehot`, `gnt_idx` and `any`.
  - Uses a masked/unmasked double priority encode.
- **Top module:** lock FSM, muxes and handshake gating.

## Test plan
1. **Round-robin order:** `num_req`=4, all valid, single-beat bursts, `out_ready`=1 → `out_id` sequence 0,1,2,3,0,1.
2. **Burst lock:** req1 sends 3 beats (last on the 3rd) while req0/req2 are valid → `out_id`=1 ×3, `busy`=1 for the 2nd and 3rd cycles, then grant 2 (ptr=2).
3. **Backpressure:** `out_ready`=0 for 5 cycles mid-burst of req3 → `req_ready`=0 everywhere, `busy` held, data stable. On release the burst resumes on req3.
4. **Flush mid-burst:** req2 LOCKED, assert `flush` one cycle → no `req_ready` that cycle. Next cycle is IDLE with ptr=0, so req0 wins over req2.
5. **Wrap:** ptr=3, only req0 and req3 valid, single beats → order 3,0,3,0.
6. **Async reset:** `rst_n` low mid-LOCKED, off-edge → `busy`=0 immediately. After release all outputs are 0 while idle.
